// File: rtl/z80_bus_mem_responder.sv
// rtl/z80_bus_mem_responder.sv - tv80s bus slave: RAM, I/O, wait states, write log, M1 counter
module z80_bus_mem_responder #(
    parameter int         WAIT_MEM  = 0,
    parameter int         WAIT_IO   = 0,
    parameter int         LOG_DEPTH = 8,
    parameter logic [7:0] IM2_VEC   = 8'hff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        log_valid,
    output logic [24:0] log_data,
    input  logic        log_pop,
    output logic        log_ovf,
    output logic [31:0] m1_count
);
    localparam int          PW      = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [3:0]  WM_LOAD = (WAIT_MEM > 0) ? 4'(WAIT_MEM - 1) : 4'd0;
    localparam logic [3:0]  WI_LOAD = (WAIT_IO > 0) ? 4'(WAIT_IO - 1) : 4'd0;
    localparam logic [PW:0] DEPTH   = (PW + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;
    typedef enum logic [1:0] {K_MEM, K_IO, K_IACK} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          done_q, done_d;
    logic [31:0]   m1_count_q, m1_count_d;
    logic [7:0]    di_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          commit, push_ok, pop_ok;
    logic [24:0]   log_entry;

    logic [7:0]    mem    [0:65535];
    logic [7:0]    io_mem [0:255];
    logic [24:0]   log_mem[0:LOG_DEPTH-1];

    // Bus-cycle FSM: decode cycle kind on IDLE exit, count wait states, commit one write per cycle
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        wcnt_d     = wcnt_q;
        done_d     = done_q;
        m1_count_d = m1_count_q;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (!mreq_n && rfsh_n) begin
                    kind_d = K_MEM;
                    if (!m1_n && !rd_n) m1_count_d = m1_count_q + 32'd1;
                    if (WAIT_MEM != 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WM_LOAD;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (!iorq_n && m1_n) begin
                    kind_d = K_IO;
                    if (WAIT_IO != 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WI_LOAD;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (!iorq_n && !m1_n) begin
                    kind_d  = K_IACK;
                    state_d = ST_ACTIVE;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) state_d = ST_ACTIVE;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ACTIVE: begin
                if (kind_q != K_IACK && !wr_n && !done_q) begin
                    commit = 1'b1;
                    done_d = 1'b1;
                end
                if (mreq_n && iorq_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-log FIFO control: a pop frees the slot before the same-cycle push is judged
    always_comb begin
        pop_ok    = log_pop && (count_q != '0);
        push_ok   = commit && ((count_q != DEPTH) || pop_ok);
        wr_ptr_d  = wr_ptr_q + PW'(push_ok);
        rd_ptr_d  = rd_ptr_q + PW'(pop_ok);
        count_d   = count_q + (PW + 1)'(push_ok) - (PW + 1)'(pop_ok);
        ovf_d     = ovf_q | (commit & ~push_ok);
        log_entry = {kind_q == K_IO, A, dout};
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= K_MEM;
            wcnt_q     <= 4'd0;
            done_q     <= 1'b0;
            m1_count_q <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            wcnt_q     <= wcnt_d;
            done_q     <= done_d;
            m1_count_q <= m1_count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage writes; CPU write is last so it beats a same-address backdoor write
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        if (commit && kind_q == K_MEM) mem[A] <= dout;
        if (commit && kind_q == K_IO) io_mem[A[7:0]] <= dout;
        if (push_ok) log_mem[wr_ptr_q] <= log_entry;
    end

    // Read data launched on the falling edge so it is settled for the CPU's next rising-edge sample
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            di_q <= 8'hff;
        end else if (state_q != ST_IDLE) begin
            case (kind_q)
                K_MEM:   di_q <= mem[A];
                K_IO:    di_q <= io_mem[A[7:0]];
                default: di_q <= IM2_VEC;
            endcase
        end
    end

    assign di        = di_q;
    assign wait_n    = (state_q != ST_WAIT);
    assign log_valid = (count_q != '0);
    assign log_data  = log_mem[rd_ptr_q];
    assign log_ovf   = ovf_q;
    assign m1_count  = m1_count_q;
endmodule

// File: tb/tb_z80_bus_mem_responder.sv
// tb/tb_z80_bus_mem_responder.sv - bus-cycle driver and reference model for z80_bus_mem_responder
module tb_z80_bus_mem_responder;
    localparam int WM_B = 2;
    localparam int WI_B = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] A = 16'h0;
    logic [7:0] dout = 8'h0;
    logic m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic ld_we = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [7:0] ld_data = 8'h0;
    logic log_pop = 1'b0;

    logic [7:0]  di_a, di_b;
    logic        wait_n_a, wait_n_b, log_valid_a, log_valid_b, log_ovf_a, log_ovf_b;
    logic [24:0] log_data_a, log_data_b;
    logic [31:0] m1_count_a, m1_count_b;

    z80_bus_mem_responder #(.WAIT_MEM(0), .WAIT_IO(0), .LOG_DEPTH(8), .IM2_VEC(8'hff)) u_dut_a (
        .clk(clk), .reset(reset), .A(A), .dout(dout), .di(di_a),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .wait_n(wait_n_a), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .log_valid(log_valid_a), .log_data(log_data_a), .log_pop(log_pop),
        .log_ovf(log_ovf_a), .m1_count(m1_count_a));

    z80_bus_mem_responder #(.WAIT_MEM(WM_B), .WAIT_IO(WI_B), .LOG_DEPTH(8), .IM2_VEC(8'hA5)) u_dut_b (
        .clk(clk), .reset(reset), .A(A), .dout(dout), .di(di_b),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .wait_n(wait_n_b), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .log_valid(log_valid_b), .log_data(log_data_b), .log_pop(log_pop),
        .log_ovf(log_ovf_b), .m1_count(m1_count_b));

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mem_m [0:65535];
    logic [7:0]  io_m  [0:255];
    bit          io_known [0:255];
    logic [24:0] log_q [$];
    logic        ovf_m = 1'b0;
    int unsigned m1_m = 0;
    int          n_cmp = 0, n_bad = 0;
    int          wcnt_a = 0, wcnt_b = 0;

    // Cumulative count of clocks each DUT holds wait_n low
    always @(negedge clk) begin
        if (!wait_n_a) wcnt_a <= wcnt_a + 1;
        if (!wait_n_b) wcnt_b <= wcnt_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic backdoor(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk); #1;
        ld_we = 1'b1; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_we = 1'b0;
        mem_m[addr] = data;
    endtask

    // kind: 0 = memory, 1 = I/O, 2 = interrupt acknowledge
    task automatic cpu_cycle(input int kind, input logic [15:0] addr, input logic we, input logic [7:0] wd,
                             input logic is_m1, input logic do_pop, input logic ld_clash);
        int sa, sb, guard, exp_wb;
        logic [7:0] exp_rd;
        logic rd_chk;
        exp_rd = 8'h00;
        rd_chk = 1'b0;
        if (!we && kind == 0) begin exp_rd = mem_m[addr]; rd_chk = 1'b1; end
        if (!we && kind == 1) begin exp_rd = io_m[addr[7:0]]; rd_chk = io_known[addr[7:0]]; end
        exp_wb = (kind == 0) ? WM_B : (kind == 1) ? WI_B : 0;
        @(posedge clk); #1;
        A = addr;
        m1_n = !(is_m1 || kind == 2);
        @(negedge clk); #1;
        if (kind == 0) mreq_n = 1'b0; else iorq_n = 1'b0;
        if (!we && kind != 2) rd_n = 1'b0;
        if (we) dout = wd;
        sa = wcnt_a; sb = wcnt_b;
        @(posedge clk); #1;
        guard = 0;
        while (!(wait_n_a && wait_n_b) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("wait_release", {30'd0, wait_n_a, wait_n_b}, 32'd3);
        @(negedge clk); #1;
        if (we) wr_n = 1'b0;
        if (ld_clash) begin ld_we = 1'b1; ld_addr = addr; ld_data = ~wd; end
        if (do_pop) begin
            check_eq("pop_valid_a", log_valid_a, log_q.size() > 0);
            check_eq("pop_valid_b", log_valid_b, log_q.size() > 0);
            if (log_q.size() > 0) begin
                check_eq("pop_head_a", log_data_a, log_q[0]);
                check_eq("pop_head_b", log_data_b, log_q[0]);
            end
            log_pop = 1'b1;
        end
        @(posedge clk); #1;
        log_pop = 1'b0;
        ld_we = 1'b0;
        if (rd_chk) begin
            check_eq("rd_a", di_a, exp_rd);
            check_eq("rd_b", di_b, exp_rd);
        end
        if (kind == 2) begin
            check_eq("iack_a", di_a, 8'hff);
            check_eq("iack_b", di_b, 8'hA5);
        end
        if (do_pop && log_q.size() > 0) void'(log_q.pop_front());
        if (we) begin
            if (kind == 0) mem_m[addr] = wd;
            else begin io_m[addr[7:0]] = wd; io_known[addr[7:0]] = 1'b1; end
            if (log_q.size() < 8) log_q.push_back({kind == 1, addr, wd});
            else ovf_m = 1'b1;
        end
        if (kind == 0 && is_m1 && !we) m1_m++;
        @(negedge clk); #1;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        check_eq("wait_cnt_a", wcnt_a - sa, 0);
        check_eq("wait_cnt_b", wcnt_b - sb, exp_wb);
        @(posedge clk); #1;
        if (kind == 0 && is_m1) begin
            rfsh_n = 1'b0;
            A = 16'($urandom_range(0, 127));
            sa = wcnt_a; sb = wcnt_b;
            @(negedge clk); #1 mreq_n = 1'b0;
            @(posedge clk);
            @(negedge clk); #1 mreq_n = 1'b1;
            @(posedge clk); #1 rfsh_n = 1'b1;
            check_eq("rfsh_wait_a", wcnt_a - sa, 0);
            check_eq("rfsh_wait_b", wcnt_b - sb, 0);
        end
    endtask

    task automatic pop_log();
        @(negedge clk); #1;
        check_eq("log_valid_a", log_valid_a, log_q.size() > 0);
        check_eq("log_valid_b", log_valid_b, log_q.size() > 0);
        if (log_q.size() > 0) begin
            check_eq("log_data_a", log_data_a, log_q[0]);
            check_eq("log_data_b", log_data_b, log_q[0]);
            void'(log_q.pop_front());
        end
        log_pop = 1'b1;
        @(posedge clk); #1;
        log_pop = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && log_q.size() > 0; k++) pop_log();
        pop_log();
    endtask

    task automatic check_status();
        @(negedge clk); #1;
        check_eq("m1_count_a", m1_count_a, m1_m);
        check_eq("m1_count_b", m1_count_b, m1_m);
        check_eq("log_ovf_a", log_ovf_a, ovf_m);
        check_eq("log_ovf_b", log_ovf_b, ovf_m);
        check_eq("log_valid_a", log_valid_a, log_q.size() > 0);
        check_eq("log_valid_b", log_valid_b, log_q.size() > 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wait_a"}, wait_n_a, 1'b1);
        check_eq({tag, "_wait_b"}, wait_n_b, 1'b1);
        check_eq({tag, "_di_a"}, di_a, 8'hff);
        check_eq({tag, "_di_b"}, di_b, 8'hff);
        check_eq({tag, "_valid_a"}, log_valid_a, 1'b0);
        check_eq({tag, "_valid_b"}, log_valid_b, 1'b0);
        check_eq({tag, "_ovf_a"}, log_ovf_a, 1'b0);
        check_eq({tag, "_ovf_b"}, log_ovf_b, 1'b0);
        check_eq({tag, "_m1_a"}, m1_count_a, 32'd0);
        check_eq({tag, "_m1_b"}, m1_count_b, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [15:0] ad;
        repeat (2) @(negedge clk);
        #1 check_reset_state("rst0");
        reset = 1'b0;
        for (int i = 0; i < 32; i++) backdoor(16'h4000 + 16'(i), 8'($urandom));

        // Program LD A,5Ah / LD (8000h),A as bus cycles
        backdoor(16'h0000, 8'h3E); backdoor(16'h0001, 8'h5A); backdoor(16'h0002, 8'h32);
        backdoor(16'h0003, 8'h00); backdoor(16'h0004, 8'h80); backdoor(16'h8000, 8'h00);
        cpu_cycle(0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0002, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0003, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0004, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h8000, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_eq("t1_m1", m1_count_a, 32'd2);
        check_eq("t1_log", log_data_a, {1'b0, 16'h8000, 8'h5A});
        drain();
        cpu_cycle(0, 16'h8000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // OUT (12h),A with A=77h
        cpu_cycle(1, 16'h7712, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_eq("t3_log", log_data_b, {1'b1, 16'h7712, 8'h77});
        drain();
        cpu_cycle(1, 16'h3312, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h8000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(2, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // CPU write colliding with a backdoor write to the same address
        cpu_cycle(0, 16'h4010, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        cpu_cycle(0, 16'h4010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain();

        // BIT 0,(IY+3Bh) bus pattern: only reads, nothing logged
        backdoor(16'h0000, 8'hFD); backdoor(16'h0001, 8'hCB); backdoor(16'h0002, 8'h3B);
        backdoor(16'h0003, 8'h40); backdoor(16'h41D0, 8'h0D);
        cpu_cycle(0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0001, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0002, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h0003, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h41D0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_status();
        cpu_cycle(0, 16'h41D0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Overflow: nine writes into an 8-deep log, then push+pop while full
        for (int i = 0; i < 8; i++) cpu_cycle(0, 16'h4000 + 16'(i), 1'b1, 8'(i * 3 + 1), 1'b0, 1'b0, 1'b0);
        check_eq("t4_ovf_pre", log_ovf_a, 1'b0);
        cpu_cycle(0, 16'h4008, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        check_status();
        drain();
        for (int i = 0; i < 8; i++) cpu_cycle(1, 16'hA000 + 16'(i), 1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h4009, 1'b1, 8'hB7, 1'b0, 1'b1, 1'b0);
        check_status();
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            ad = 16'h4000 + 16'($urandom_range(0, 31));
            case (op)
                0, 1, 2: cpu_cycle(0, ad, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                3, 4:    cpu_cycle(0, ad, 1'b1, 8'($urandom), 1'b0,
                                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
                5:       cpu_cycle(1, {8'($urandom), 8'($urandom_range(0, 15))}, 1'b1, 8'($urandom),
                                   1'b0, ($urandom_range(0, 2) == 0), 1'b0);
                6:       cpu_cycle(1, {8'($urandom), 8'($urandom_range(0, 15))}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                7:       cpu_cycle(2, 16'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                8:       backdoor(ad, 8'($urandom));
                default: pop_log();
            endcase
            if (n % 50 == 49) check_status();
        end
        check_status();
        drain();

        // Reset while DUT b is inserting wait states on a memory write
        backdoor(16'h4005, 8'h11);
        @(posedge clk); #1;
        A = 16'h4005; m1_n = 1'b1;
        @(negedge clk); #1;
        mreq_n = 1'b0; dout = 8'h99;
        @(posedge clk); #1;
        check_eq("t5_in_wait_b", wait_n_b, 1'b0);
        @(negedge clk); #1;
        wr_n = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_state("rst1");
        @(posedge clk);
        @(negedge clk); #1;
        mreq_n = 1'b1; wr_n = 1'b1;
        #2 reset = 1'b0;
        log_q.delete();
        ovf_m = 1'b0;
        m1_m = 0;
        cpu_cycle(0, 16'h4005, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cpu_cycle(0, 16'h4006, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_status();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
